sm_fv_bank_cntl: RTL and testbench



---
 rtl/sm_fv_bank_cntl_pkg.sv | 34 +++
 rtl/sm_fv_rd_pipe.sv | 51 +++++
 rtl/sm_fv_bank_cntl.sv | 203 ++++++++++++++++++++
 tb/tb_sm_fv_bank_cntl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_fv_bank_cntl_pkg.sv
// Shared types and constants for the small feature-value bank controller.
// Stream and read-out bundles mirror the big FV bank formats.
package sm_fv_bank_cntl_pkg;

  localparam int FV_BANDWIDTH   = 32;
  localparam int MAX_FV_NUM     = 16;
  localparam int NUM_EDGE_PE    = 4;
  localparam int SM_ADDR_W      = 7;
  localparam int SM_LINE_W      = 3;
  localparam int SM_TAG_W       = $clog2(NUM_EDGE_PE);
  localparam int LINES_PER_NODE = 1 << SM_LINE_W;

  typedef struct packed {
    logic                    sos;
    logic                    eos;
    logic [SM_ADDR_W-1:0]    A;
    logic [FV_BANDWIDTH-1:0] FV_data;
  } FV_MEM2FV_Bank;

  typedef struct packed {
    logic                    valid;
    logic                    sos;
    logic                    eos;
    logic [FV_BANDWIDTH-1:0] FV_data;
    logic [SM_TAG_W-1:0]     PE_tag;
  } FV_bank_CNTL2Edge_PE;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READ
  } sm_fv_state_t;

endpackage

// File: rtl/sm_fv_rd_pipe.sv
// Read-out pipeline: SRAM-issue flag stage plus registered output beat.
// A squash kills the beat whose data is returning this cycle.
module sm_fv_rd_pipe
  import sm_fv_bank_cntl_pkg::*;
#(
  parameter int FV_BW = FV_BANDWIDTH,
  parameter int TAG_W = SM_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic                first,
  input  logic                last,
  input  logic [TAG_W-1:0]    tag,
  input  logic                squash,
  input  logic [FV_BW-1:0]    rdata,
  output FV_bank_CNTL2Edge_PE out,
  output logic                abort
);

  logic             iss_q;
  logic             first_q;
  logic             last_q;
  logic [TAG_W-1:0] tag_q;
  logic             take;

  assign take = iss_q && !squash;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      tag_q   <= '0;
      out     <= '0;
      abort   <= 1'b0;
    end else begin
      iss_q       <= issue && !squash;
      first_q     <= first;
      last_q      <= last;
      tag_q       <= tag;
      out.valid   <= take;
      out.sos     <= take && first_q;
      out.eos     <= take && last_q;
      out.FV_data <= take ? rdata : '0;
      out.PE_tag  <= take ? tag_q : '0;
      abort       <= squash;
    end
  end

endmodule

// File: rtl/sm_fv_bank_cntl.sv
// Small FV bank controller: captures the fill stream into a local SRAM
// and serves multi-line sos/eos bursts to the Edge PEs.
module sm_fv_bank_cntl
  import sm_fv_bank_cntl_pkg::*;
#(
  parameter int FV_BW  = FV_BANDWIDTH,
  parameter int ADDR_W = SM_ADDR_W,
  parameter int LINE_W = SM_LINE_W,
  parameter int FVN_W  = $clog2(MAX_FV_NUM) + 1,
  parameter int TAG_W  = SM_TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_sos,
  input  logic                     st_eos,
  input  logic [ADDR_W-1:0]        st_A,
  input  logic [FV_BW-1:0]         st_data,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-LINE_W-1:0] req_node,
  input  logic [FVN_W-1:0]         req_fv_num,
  input  logic [TAG_W-1:0]         req_PE_tag,
  output logic                     sram_CEN,
  output logic                     sram_WEN,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [FV_BW-1:0]         sram_wdata,
  input  logic [FV_BW-1:0]         sram_rdata,
  output logic                     rd_valid,
  output logic                     rd_sos,
  output logic                     rd_eos,
  output logic [FV_BW-1:0]         rd_data,
  output logic [TAG_W-1:0]         rd_PE_tag,
  output logic                     rd_abort,
  output logic                     loaded
);

  sm_fv_state_t state, nxt;

  logic [LINE_W:0]          cnt;
  logic [LINE_W:0]          nlines;
  logic [LINE_W:0]          req_lines;
  logic [FVN_W:0]           half;
  logic [ADDR_W-LINE_W-1:0] node;
  logic [TAG_W-1:0]         tag;
  logic                     loaded_q;
  logic                     wr;
  logic                     issue;
  logic                     first;
  logic                     last;
  logic                     abort;
  logic                     accept;
  logic                     ld_set;
  logic                     ld_clr;
  logic                     cnt_inc;
  logic [ADDR_W-1:0]        rd_addr;
  FV_MEM2FV_Bank            st;
  FV_bank_CNTL2Edge_PE      rd;

  assign st = {st_sos, st_eos, st_A, st_data};

  // Two values per line; zero still returns one line, clamp at a node.
  always_comb begin
    half = ({1'b0, req_fv_num} + 1'b1) >> 1;
    if (half == '0)
      req_lines = (LINE_W+1)'(1);
    else if (half > (FVN_W+1)'(LINES_PER_NODE))
      req_lines = (LINE_W+1)'(LINES_PER_NODE);
    else
      req_lines = half[LINE_W:0];
  end

  always_comb begin
    nxt     = state;
    wr      = 1'b0;
    issue   = 1'b0;
    first   = 1'b0;
    last    = 1'b0;
    abort   = 1'b0;
    accept  = 1'b0;
    ld_set  = 1'b0;
    ld_clr  = 1'b0;
    cnt_inc = 1'b0;
    rd_addr = '0;
    unique case (state)
      S_IDLE: begin
        if (st.sos) begin
          wr = 1'b1;
          if (st.eos) begin
            ld_set = 1'b1;
          end else begin
            ld_clr = 1'b1;
            nxt    = S_FILL;
          end
        end else if (req_valid && loaded_q) begin
          accept  = 1'b1;
          issue   = 1'b1;
          first   = 1'b1;
          last    = (req_lines == (LINE_W+1)'(1));
          rd_addr = {req_node, {LINE_W{1'b0}}};
          nxt     = S_READ;
        end
      end
      S_FILL: begin
        wr = 1'b1;
        if (st.eos) begin
          ld_set = 1'b1;
          nxt    = S_IDLE;
        end else if (st.sos) begin
          ld_clr = 1'b1;
        end
      end
      S_READ: begin
        if (st.sos) begin
          wr    = 1'b1;
          abort = 1'b1;
          if (st.eos) begin
            ld_set = 1'b1;
            nxt    = S_IDLE;
          end else begin
            ld_clr = 1'b1;
            nxt    = S_FILL;
          end
        end else if (cnt < nlines) begin
          issue   = 1'b1;
          cnt_inc = 1'b1;
          last    = ((cnt + 1'b1) == nlines);
          rd_addr = {node, cnt[LINE_W-1:0]};
          if ((cnt + 1'b1) >= nlines)
            nxt = S_IDLE;
        end else begin
          nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sram_CEN   = 1'b1;
    sram_WEN   = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    if (wr) begin
      sram_CEN   = 1'b0;
      sram_WEN   = 1'b0;
      sram_addr  = st.A;
      sram_wdata = st.FV_data;
    end else if (issue) begin
      sram_CEN  = 1'b0;
      sram_addr = rd_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      nlines   <= '0;
      node     <= '0;
      tag      <= '0;
      loaded_q <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        cnt    <= (LINE_W+1)'(1);
        nlines <= req_lines;
        node   <= req_node;
        tag    <= req_PE_tag;
      end else if (cnt_inc) begin
        cnt <= cnt + 1'b1;
      end
      if (ld_set)
        loaded_q <= 1'b1;
      else if (ld_clr)
        loaded_q <= 1'b0;
    end
  end

  sm_fv_rd_pipe #(
    .FV_BW (FV_BW),
    .TAG_W (TAG_W)
  ) u_rd_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .issue  (issue),
    .first  (first),
    .last   (last),
    .tag    (accept ? req_PE_tag : tag),
    .squash (abort),
    .rdata  (sram_rdata),
    .out    (rd),
    .abort  (rd_abort)
  );

  assign req_ready = (state == S_IDLE) && loaded_q && !st_sos;
  assign loaded    = loaded_q;
  assign rd_valid  = rd.valid;
  assign rd_sos    = rd.sos;
  assign rd_eos    = rd.eos;
  assign rd_data   = rd.FV_data;
  assign rd_PE_tag = rd.PE_tag;

endmodule

// File: tb/tb_sm_fv_bank_cntl.sv
// Randomized scoreboard bench for the small FV bank controller.
// Expected bursts come from a line-array model of the bank contents.
module tb_sm_fv_bank_cntl;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_sos, st_eos;
  logic [6:0]  st_A;
  logic [31:0] st_data;
  logic        req_valid, req_ready;
  logic [3:0]  req_node;
  logic [4:0]  req_fv_num;
  logic [1:0]  req_PE_tag;
  logic        sram_CEN, sram_WEN;
  logic [6:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        rd_valid, rd_sos, rd_eos, rd_abort, loaded;
  logic [31:0] rd_data;
  logic [1:0]  rd_PE_tag;

  always #5 clk = ~clk;

  sm_fv_bank_cntl dut (
    .clk        (clk),
    .reset      (reset),
    .st_sos     (st_sos),
    .st_eos     (st_eos),
    .st_A       (st_A),
    .st_data    (st_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_node   (req_node),
    .req_fv_num (req_fv_num),
    .req_PE_tag (req_PE_tag),
    .sram_CEN   (sram_CEN),
    .sram_WEN   (sram_WEN),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .rd_valid   (rd_valid),
    .rd_sos     (rd_sos),
    .rd_eos     (rd_eos),
    .rd_data    (rd_data),
    .rd_PE_tag  (rd_PE_tag),
    .rd_abort   (rd_abort),
    .loaded     (loaded)
  );

  typedef struct {
    logic [31:0] data;
    logic        sos;
    logic        eos;
    logic [1:0]  tag;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mb;
  logic [31:0] sram[128];
  logic [31:0] ref_mem[128];
  bit          ref_loaded;
  int          cyc = 0;
  int          abort_cyc = -1;
  int          n_pass = 0;
  int          n_total = 0;

  // behavioural single-port SRAM, one-cycle read latency
  always @(posedge clk) begin
    if (!sram_CEN) begin
      if (!sram_WEN) sram[sram_addr] <= sram_wdata;
      else sram_rdata <= sram[sram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mb = exp_q.pop_front();
          check("beat", {rd_sos, rd_eos, rd_PE_tag, rd_data},
                {mb.sos, mb.eos, mb.tag, mb.data});
          check("beat_cycle", cyc, mb.cyc);
        end
      end
      if (rd_abort || cyc == abort_cyc)
        check("rd_abort", rd_abort, cyc == abort_cyc);
    end
  end

  task automatic beat(logic sos, logic eos, logic [6:0] a, logic [31:0] d);
    st_sos = sos; st_eos = eos; st_A = a; st_data = d;
    @(negedge clk);
    check("wr_en", {sram_CEN, sram_WEN}, 2'b00);
    check("wr_addr_data", {sram_addr, sram_wdata}, {a, d});
    ref_mem[a] = d;
    if (sos) ref_loaded = 0;
    if (eos) ref_loaded = 1;
    @(posedge clk); #1;
    st_sos = 0; st_eos = 0;
  endtask

  task automatic fill(int base, int len, bit rnd);
    for (int k = 0; k < len; k++) begin
      beat(k == 0, k == len - 1, 7'(base + k),
           rnd ? $urandom : 32'((base + k) * 3));
      if (k == 1 && len > 2) check("loaded_mid_fill", loaded, 0);
    end
    @(negedge clk);
    check("loaded_after_eos", loaded, ref_loaded);
    @(posedge clk); #1;
  endtask

  task automatic do_read(logic [3:0] node, logic [4:0] fvn,
                         logic [1:0] tag, output int t);
    int n;
    req_valid = 1; req_node = node;
    req_fv_num = fvn; req_PE_tag = tag;
    t = -1;
    for (int w = 0; w < 64 && t < 0; w++) begin
      @(negedge clk);
      if (req_ready) begin
        t = cyc;
        check("rd_issue", {sram_CEN, sram_WEN, sram_addr},
              {2'b01, node, 3'b000});
      end
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (t < 0) begin
      check("req_timeout", 0, 1);
    end else begin
      n = (int'(fvn) + 1) / 2;
      if (n < 1) n = 1;
      if (n > 8) n = 8;
      for (int i = 0; i < n; i++)
        exp_q.push_back('{data: ref_mem[int'(node) * 8 + i],
                          sos: (i == 0), eos: (i == n - 1),
                          tag: tag, cyc: t + 2 + i});
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 64 && exp_q.size() > 0; w++) begin
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 128; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    ref_loaded = 0;
    reset = 0; st_sos = 0; st_eos = 0; st_A = 0; st_data = 0;
    req_valid = 0; req_node = 0; req_fv_num = 0; req_PE_tag = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rd", {rd_valid, rd_sos, rd_eos, rd_data, rd_PE_tag,
                       rd_abort, loaded}, 0);
    check("reset_sram", {sram_CEN, sram_WEN, sram_addr, sram_wdata},
          {2'b11, 39'd0});
    reset = 1;

    // requests before the bank is loaded must stall with no SRAM traffic
    req_valid = 1; req_node = 0; req_fv_num = 4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ready_unloaded", {req_ready, sram_CEN}, 2'b01);
      @(posedge clk); #1;
    end
    req_valid = 0;

    fill(0, 32, 0);
    do_read(2, 16, 1, t); drain();
    do_read(0, 3, 2, t);  drain();
    do_read(1, 0, 3, t);  drain();
    do_read(3, 16, 0, t); drain();
    do_read(3, 31, 1, t); drain();

    for (int i = 0; i < 20; i++)
      do_read(4'($urandom_range(0, 3)), 5'($urandom_range(0, 17)),
              2'($urandom), t);
    drain();

    // one-beat stream in IDLE
    beat(1, 1, 7'd40, $urandom);
    check("loaded_one_beat", loaded, 1);
    do_read(5, 1, 2, t); drain();

    fill(32, 32, 1);
    for (int i = 0; i < 12; i++)
      do_read(4'($urandom_range(0, 7)), 5'($urandom_range(0, 16)),
              2'($urandom), t);
    drain();

    // stream collides with a read on its third cycle
    do_read(4, 16, 3, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    while (exp_q.size() > 0 && exp_q[$].cyc > t + 3) void'(exp_q.pop_back());
    abort_cyc = t + 4;
    beat(1, 0, 7'd64, $urandom);
    check("loaded_collide", loaded, 0);
    beat(0, 0, 7'd65, $urandom);
    check("loaded_collide_fill", loaded, 0);
    beat(0, 1, 7'd66, $urandom);
    check("loaded_collide_eos", loaded, 1);
    drain();
    do_read(8, 6, 1, t); drain();

    // reset while the fourth beat is on the output
    do_read(0, 16, 2, t);
    repeat (4) begin @(posedge clk); #1; end
    reset = 0;
    #1;
    check("reset_mid_rd", {rd_valid, rd_sos, rd_eos, rd_data, rd_PE_tag,
                           rd_abort, loaded}, 0);
    check("reset_mid_sram", {sram_CEN, req_ready}, 2'b10);
    exp_q.delete();
    ref_loaded = 0;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    check("post_reset_ready", {loaded, req_ready}, 2'b00);
    @(posedge clk); #1;
    fill(0, 16, 1);
    do_read(1, 16, 0, t); drain();
    do_read(0, 9, 3, t);  drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
